// File: rtl/mat_stream_collect.sv
// mat_stream_collect
//   Gathers a row-major stream of matrix elements into the flattened bus
//   consumed by the combinational determinant stage. A collect register
//   assembles the next frame while an output register holds the previous one
//   stable on a valid/ready handshake. Frames whose in_last marker does not
//   line up with the final element are discarded and counted.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_data     current element (two's complement, passed through)
//   in_valid    in_data valid
//   in_last     final element of a frame, qualified by in_valid
//   in_ready    element can be accepted this cycle
//   out_matrix  flattened matrix, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid   out_matrix holds a complete frame
//   out_ready   downstream takes out_matrix this cycle
//   frame_err   one-cycle pulse: a frame was discarded
//   err_cnt     saturating count of discarded frames
module mat_stream_collect #(
    parameter int DATA_WIDTH  = 8,
    parameter int MATRIX_SIZE = 3
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [DATA_WIDTH-1:0]                           in_data,
    input  logic                                            in_valid,
    input  logic                                            in_last,
    output logic                                            in_ready,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   out_matrix,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic                                            frame_err,
    output logic [7:0]                                      err_cnt
);

    localparam int NELEM = MATRIX_SIZE * MATRIX_SIZE;
    localparam int IDX_W = $clog2(NELEM);
    localparam int MAT_W = NELEM * DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NELEM - 1);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] HOLD    = 1'b1;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [0:0]       state_p0;
    logic [IDX_W-1:0] idx_p0;
    logic [MAT_W-1:0] coll_p0;
    logic [MAT_W-1:0] coll_next;
    logic [MAT_W-1:0] mat_p1;
    logic             vld_p1;
    logic             err_p1;
    logic [7:0]       cnt_p1;

    logic accept;
    logic at_end;
    logic bad;
    logic xfer;

    // Ready is gated by rst directly so it is low for the whole reset cycle.
    assign in_ready = ~rst & (state_p0 == COLLECT);
    assign accept   = in_valid & in_ready;
    assign at_end   = (idx_p0 == LAST_IDX);
    // Malformed when the marker and the final slot disagree.
    assign bad      = accept & (in_last != at_end);
    assign xfer     = vld_p1 & out_ready;

    // Collect buffer with the incoming element already placed, so a completing
    // frame can be forwarded to the output register in the same cycle.
    always_comb begin
        coll_next = coll_p0;
        coll_next[int'(idx_p0)*DATA_WIDTH +: DATA_WIDTH] = in_data;
    end

    // Stage p0 -> p1: collect register to output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= COLLECT;
            idx_p0   <= '0;
            coll_p0  <= '0;
            mat_p1   <= '0;
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            cnt_p1   <= 8'd0;
        end else begin
            err_p1 <= bad;
            if (bad) begin
                cnt_p1 <= sat_inc(cnt_p1);
            end
            // Drop valid after a transfer; a simultaneous load below wins.
            if (xfer) begin
                vld_p1 <= 1'b0;
            end
            if (state_p0 == COLLECT) begin
                if (accept) begin
                    if (bad) begin
                        idx_p0 <= '0;
                    end else begin
                        coll_p0 <= coll_next;
                        if (at_end) begin
                            idx_p0 <= '0;
                            if (!vld_p1 || out_ready) begin
                                mat_p1 <= coll_next;
                                vld_p1 <= 1'b1;
                            end else begin
                                state_p0 <= HOLD;
                            end
                        end else begin
                            idx_p0 <= idx_p0 + IDX_W'(1);
                        end
                    end
                end
            end else begin
                // Completed frame parked in the collect buffer until the
                // output register frees up.
                if (xfer) begin
                    mat_p1   <= coll_p0;
                    vld_p1   <= 1'b1;
                    state_p0 <= COLLECT;
                end
            end
        end
    end

    assign out_matrix = mat_p1;
    assign out_valid  = vld_p1;
    assign frame_err  = err_p1;
    assign err_cnt    = cnt_p1;

endmodule
